// File: rtl/frac_logic_pkg.sv
// Shared definitions for the fracturable LUT-K logic element and its config chain.
package frac_logic_pkg;

   // Mode-bit offsets, relative to the end of the truth table in the config word.
   localparam int unsigned OUT0_SEL_OFS = 0;
   localparam int unsigned ARITH_EN_OFS = 1;

   typedef enum logic {
      LOGIC = 1'b0,
      ARITH = 1'b1
   } cfg_mode_t;

   function automatic int unsigned cfg_bits(input int unsigned k);
      return (32'd1 << k) + 32'd2;
   endfunction

endpackage

// File: rtl/ccff_count_chain.sv
// Serial configuration shift chain with a saturating bit counter and a load-complete flag.
module ccff_count_chain
   import frac_logic_pkg::*;
#(
   parameter int unsigned N = 18
) (
   input  logic         prog_clk,
   input  logic         pReset,
   input  logic         config_enable,
   input  logic         ccff_head,
   output logic [N-1:0] cfg,
   output logic         ccff_tail,
   output logic         cfg_done
);

   localparam int unsigned CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] cnt;
   logic             en_q;
   logic             cnt_full;

   assign cnt_full  = (cnt == CNT_W'(N));
   assign ccff_tail = cfg[N-1];

   // Counter restarts on each new enable burst so a partial earlier load never counts.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         cfg      <= '0;
         cnt      <= '0;
         en_q     <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         en_q     <= config_enable;
         cfg_done <= ~config_enable & cnt_full;
         if (config_enable) begin
            cfg <= {cfg[N-2:0], ccff_head};
            if (!en_q) begin
               cnt <= CNT_W'(1);
            end else if (!cnt_full) begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/frac_lutk_logic_cfg.sv
// Fracturable LUT-K logic element with carry; outputs held low until a complete config load.
module frac_lutk_logic_cfg
   import frac_logic_pkg::*;
#(
   parameter int unsigned K = 4
) (
   input  logic         prog_clk,
   input  logic         pReset,
   input  logic         config_enable,
   input  logic         ccff_head,
   input  logic [K-1:0] frac_logic_in,
   input  logic         frac_logic_cin,
   output logic [1:0]   frac_logic_out,
   output logic         frac_logic_cout,
   output logic         ccff_tail,
   output logic         cfg_done
);

   localparam int unsigned CFG_BITS = cfg_bits(K);
   localparam int unsigned TT_BITS  = 32'd1 << K;
   localparam int unsigned HALF     = 32'd1 << (K - 1);

   logic [CFG_BITS-1:0] cfg;
   logic [HALF-1:0]     t_lo;
   logic [HALF-1:0]     t_hi;
   logic [K-2:0]        idx;
   logic                lo;
   logic                hi;
   logic                lutk;
   logic                sum;
   logic                carry;
   logic                out0_sel;
   cfg_mode_t           mode;
   logic                out0_raw;
   logic                cout_raw;

   ccff_count_chain #(
      .N (CFG_BITS)
   ) u_chain (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .config_enable (config_enable),
      .ccff_head     (ccff_head),
      .cfg           (cfg),
      .ccff_tail     (ccff_tail),
      .cfg_done      (cfg_done)
   );

   assign t_lo     = cfg[HALF-1:0];
   assign t_hi     = cfg[TT_BITS-1:HALF];
   assign idx      = frac_logic_in[K-2:0];
   assign lo       = t_lo[idx];
   assign hi       = t_hi[idx];
   assign lutk     = frac_logic_in[K-1] ? hi : lo;
   assign sum      = lo ^ hi ^ frac_logic_cin;
   assign carry    = (lo & hi) | (frac_logic_cin & (lo ^ hi));
   assign out0_sel = cfg[TT_BITS + OUT0_SEL_OFS];
   assign mode     = cfg_mode_t'(cfg[TT_BITS + ARITH_EN_OFS]);

   // Output 0 selects between the lower half-LUT, the full LUT-K and the adder sum.
   always_comb begin
      out0_raw = out0_sel ? lutk : lo;
      cout_raw = 1'b0;
      if (mode == ARITH) begin
         out0_raw = sum;
         cout_raw = carry;
      end
   end

   assign frac_logic_out  = {hi & cfg_done, out0_raw & cfg_done};
   assign frac_logic_cout = cout_raw & cfg_done;

endmodule

// File: tb/tb_frac_lutk_logic_cfg.sv
// Randomised self-checking bench: two daisy-chained K=4 elements against a behavioural model.
module tb_frac_lutk_logic_cfg;

   logic       clk = 1'b0;
   logic       pReset = 1'b1;
   logic       config_enable = 1'b0;
   logic       ccff_head = 1'b0;
   logic [3:0] fin = 4'h0;
   logic       cin = 1'b0;
   logic [1:0] out;
   logic       cout, tail, done;
   logic [3:0] fin2 = 4'h0;
   logic       cin2 = 1'b0;
   logic [1:0] out2;
   logic       cout2, tail2, done2;

   int checks = 0;
   int errors = 0;

   // Model: the two chained elements form one 36-bit shift chain.
   logic [35:0] m_chain = '0;
   int          m_burst = 0;
   bit          m_prev_en = 0;
   bit          m_done = 0;

   always #5 clk = ~clk;

   frac_lutk_logic_cfg #(.K(4)) dut (
      .prog_clk(clk), .pReset(pReset), .config_enable(config_enable), .ccff_head(ccff_head),
      .frac_logic_in(fin), .frac_logic_cin(cin), .frac_logic_out(out),
      .frac_logic_cout(cout), .ccff_tail(tail), .cfg_done(done));

   frac_lutk_logic_cfg #(.K(4)) dut2 (
      .prog_clk(clk), .pReset(pReset), .config_enable(config_enable), .ccff_head(tail),
      .frac_logic_in(fin2), .frac_logic_cin(cin2), .frac_logic_out(out2),
      .frac_logic_cout(cout2), .ccff_tail(tail2), .cfg_done(done2));

   // Expected {out[1], out[0], cout, ccff_tail, cfg_done} from a config word and inputs.
   function automatic logic [4:0] frac_model(input logic [17:0] c, input logic [3:0] in,
                                             input logic ci, input bit dn);
      int   idx, s;
      logic lo, hi, lutk, o0, co;
      idx  = int'(in[2:0]);
      lo   = c[idx];
      hi   = c[8 + idx];
      lutk = in[3] ? hi : lo;
      s    = int'(lo) + int'(hi) + int'(ci);
      if (c[17]) begin
         o0 = (s % 2) == 1;
         co = (s / 2) == 1;
      end else begin
         o0 = c[16] ? lutk : lo;
         co = 1'b0;
      end
      if (!dn) return {1'b0, 1'b0, 1'b0, c[17], 1'b0};
      return {hi, o0, co, c[17], 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (pReset) begin
         m_chain = '0; m_burst = 0; m_prev_en = 0; m_done = 0;
      end else begin
         m_done = !config_enable && (m_burst >= 18);
         if (config_enable) begin
            m_chain = {m_chain[34:0], ccff_head};
            m_burst = !m_prev_en ? 1 : ((m_burst < 18) ? m_burst + 1 : 18);
         end
         m_prev_en = config_enable;
      end
      #1;
   endtask

   task automatic shift_bits(input logic [35:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         config_enable = 1'b1;
         ccff_head = w[i];
         tick();
      end
   endtask

   task automatic close_load();
      config_enable = 1'b0;
      ccff_head = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [4:0] exp;
      pReset = 1'b1;
      tick(); tick();
      checks++;
      if ({out, cout, tail, done} !== 5'b0) begin
         errors++; $display("FAIL reset_init got %b want %b", {out, cout, tail, done}, 5'b0);
      end
      pReset = 1'b0;
      shift_bits(36'h0003F, 6);
      pReset = 1'b1; config_enable = 1'b1; ccff_head = 1'b1;
      tick();
      exp = frac_model(m_chain[17:0], fin, cin, m_done);
      checks++;
      if ({out, cout, tail, done} !== 5'b0 || exp !== 5'b0) begin
         errors++; $display("FAIL reset_midshift got %b want %b", {out, cout, tail, done}, 5'b0);
      end
      pReset = 1'b0; config_enable = 1'b0; ccff_head = 1'b0;
      tick();
   endtask

   task automatic test_logic();
      shift_bits({18'h0, 2'b01, 16'h8000}, 18);
      close_load();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL logic_done got %b want 1", done);
      end
      fin = 4'hF; #1;
      checks++;
      if (out[0] !== 1'b1) begin
         errors++; $display("FAIL logic_inF got %b want 1", out[0]);
      end
      fin = 4'h7; #1;
      checks++;
      if (out[0] !== 1'b0) begin
         errors++; $display("FAIL logic_in7 got %b want 0", out[0]);
      end
      for (int i = 0; i < 16; i++) begin
         fin = 4'(i); cin = 1'(i & 1); #1;
         checks++;
         if ({out, cout, tail, done} !== frac_model(m_chain[17:0], fin, cin, m_done)) begin
            errors++; $display("FAIL logic_sweep in=%h got %b want %b", fin,
               {out, cout, tail, done}, frac_model(m_chain[17:0], fin, cin, m_done));
         end
      end
   endtask

   task automatic test_arith();
      shift_bits({18'h0, 2'b10, 16'h00FF}, 18);
      close_load();
      fin = 4'h5; cin = 1'b1; #1;
      checks++;
      if ({out[0], cout} !== 2'b01) begin
         errors++; $display("FAIL arith_cin1 got %b want 01", {out[0], cout});
      end
      cin = 1'b0; #1;
      checks++;
      if ({out[0], cout} !== 2'b10) begin
         errors++; $display("FAIL arith_cin0 got %b want 10", {out[0], cout});
      end
   endtask

   task automatic test_under_shift();
      shift_bits(36'(~32'h0), 17);
      close_load();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL under_done got %b want 0", done);
      end
      for (int i = 0; i < 32; i++) begin
         fin = 4'(i); cin = 1'(i >> 4); #1;
         checks++;
         if ({out, cout} !== 3'b000) begin
            errors++; $display("FAIL under_out in=%h got %b want 000", fin, {out, cout});
         end
      end
   endtask

   task automatic test_over_shift();
      logic [19:0] w;
      w = 20'($urandom);
      for (int i = 19; i >= 0; i--) begin
         config_enable = 1'b1; ccff_head = w[i];
         tick();
         if (i <= 2) begin
            checks++;
            if (tail !== w[i + 17]) begin
               errors++; $display("FAIL over_tail shift=%0d got %b want %b", 20 - i, tail, w[i + 17]);
            end
         end
      end
      close_load();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL over_done got %b want 1", done);
      end
      config_enable = 1'b1; ccff_head = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL over_reassert got %b want 0", done);
      end
      shift_bits(36'h0, 17);
      close_load();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL over_restart got %b want 1", done);
      end
   endtask

   task automatic test_chain();
      shift_bits({2'b01, 16'hA5C3, 2'b10, 16'h0F0F}, 36);
      close_load();
      checks++;
      if ({done, done2} !== 2'b11) begin
         errors++; $display("FAIL chain_done got %b want 11", {done, done2});
      end
      for (int i = 0; i < 16; i++) begin
         fin = 4'(i); fin2 = 4'(15 - i); cin = 1'(i & 1); cin2 = 1'((i >> 1) & 1); #1;
         checks++;
         if ({out, cout, tail, done} !== frac_model(m_chain[17:0], fin, cin, m_done) ||
             {out2, cout2, tail2, done2} !== frac_model(m_chain[35:18], fin2, cin2, m_done)) begin
            errors++; $display("FAIL chain_func in=%h/%h got %b/%b want %b/%b", fin, fin2,
               {out, cout, tail, done}, {out2, cout2, tail2, done2},
               frac_model(m_chain[17:0], fin, cin, m_done), frac_model(m_chain[35:18], fin2, cin2, m_done));
         end
      end
   endtask

   task automatic test_random();
      int len;
      for (int b = 0; b < 24; b++) begin
         len = int'($urandom_range(14, 40));
         for (int i = 0; i < len + 5; i++) begin
            config_enable = (i < len);
            ccff_head = 1'($urandom);
            pReset = ($urandom_range(0, 199) == 0);
            tick();
            pReset = 1'b0;
            for (int k = 0; k < 2; k++) begin
               fin = 4'($urandom); fin2 = 4'($urandom); cin = 1'($urandom); cin2 = 1'($urandom); #1;
               checks++;
               if ({out, cout, tail, done} !== frac_model(m_chain[17:0], fin, cin, m_done) ||
                   {out2, cout2, tail2, done2} !== frac_model(m_chain[35:18], fin2, cin2, m_done)) begin
                  errors++; $display("FAIL random b=%0d i=%0d got %b/%b want %b/%b", b, i,
                     {out, cout, tail, done}, {out2, cout2, tail2, done2},
                     frac_model(m_chain[17:0], fin, cin, m_done), frac_model(m_chain[35:18], fin2, cin2, m_done));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_logic();
      test_arith();
      test_under_shift();
      test_over_shift();
      test_chain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
